// File: rtl/spi_slave.sv
// Receive-side SPI endpoint: oversampled sclk/cs/mosi, MSB-first bytes or 4-byte words, one-cycle valid strobe.
// Optional `frame_error` output is enabled with macro SPI_SLAVE_FRAME_ERR_EN.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    input  logic        is_data_width_8,
    output logic [31:0] data,
    output logic        is_data_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic        frame_error
`endif
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BIT_CW  = 3;
    localparam int unsigned BYTE_CW = 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_d;
    logic                   cs_d;

    logic                   sclk_rise_q;
    logic                   cs_fall_q;
    logic                   cs_rise_q;
    logic                   mosi_q;

    state_t                 state_q,    state_nxt;
    logic [BIT_CW-1:0]      bit_cnt_q,  bit_cnt_nxt;
    logic [BYTE_CW-1:0]     byte_cnt_q, byte_cnt_nxt;
    logic [BYTE_W-1:0]      shreg_q,    shreg_nxt;
    logic [DATA_W-9:0]      word_q,     word_nxt;
    logic                   width8_q,   width8_nxt;
    logic [DATA_W-1:0]      data_nxt;
    logic                   valid_nxt;
    logic [BYTE_W-1:0]      byte_v;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                   ferr_nxt;
`endif

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronisers plus registered edge events. cs resets low so a cs held low
    // across reset release produces no fall until it has been seen high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync   <= '0;
            cs_sync     <= '0;
            mosi_sync   <= '0;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_d;
            cs_fall_q   <= ~cs_s & cs_d;
            cs_rise_q   <= cs_s & ~cs_d;
            mosi_q      <= mosi_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shreg_q       <= '0;
            word_q        <= '0;
            width8_q      <= 1'b1;
            data          <= '0;
            is_data_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_error   <= 1'b0;
`endif
        end else begin
            state_q       <= state_nxt;
            bit_cnt_q     <= bit_cnt_nxt;
            byte_cnt_q    <= byte_cnt_nxt;
            shreg_q       <= shreg_nxt;
            word_q        <= word_nxt;
            width8_q      <= width8_nxt;
            data          <= data_nxt;
            is_data_valid <= valid_nxt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_error   <= ferr_nxt;
`endif
        end
    end

    // Next-state logic; within SHIFT a completing sclk edge is applied before a coincident cs rise.
    always_comb begin
        state_nxt    = state_q;
        bit_cnt_nxt  = bit_cnt_q;
        byte_cnt_nxt = byte_cnt_q;
        shreg_nxt    = shreg_q;
        word_nxt     = word_q;
        width8_nxt   = width8_q;
        data_nxt     = data;
        valid_nxt    = 1'b0;
        byte_v       = {shreg_q[BYTE_W-2:0], mosi_q};
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ferr_nxt     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_nxt = SHIFT;
                    if (byte_cnt_q == '0) begin
                        width8_nxt = is_data_width_8;
                    end else if (is_data_width_8) begin
                        byte_cnt_nxt = '0;
                        word_nxt     = '0;
                        width8_nxt   = 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        ferr_nxt     = 1'b1;
`endif
                    end
                end
            end
            SHIFT: begin
                if (sclk_rise_q) begin
                    shreg_nxt   = byte_v;
                    bit_cnt_nxt = BIT_CW'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == BIT_CW'(7)) begin
                        if (width8_q) begin
                            data_nxt  = {24'h0, byte_v};
                            valid_nxt = 1'b1;
                        end else begin
                            word_nxt     = {word_q[15:0], byte_v};
                            byte_cnt_nxt = BYTE_CW'(byte_cnt_q + 1'b1);
                            if (byte_cnt_q == BYTE_CW'(3)) begin
                                data_nxt  = {word_q, byte_v};
                                valid_nxt = 1'b1;
                            end
                        end
                    end
                end
                if (cs_rise_q) begin
                    state_nxt = IDLE;
                    if (bit_cnt_nxt != '0) begin
                        bit_cnt_nxt  = '0;
                        byte_cnt_nxt = '0;
                        word_nxt     = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        ferr_nxt     = 1'b1;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus pushes expected units, a negedge monitor pops and checks data and latency.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        width8;
    logic [31:0] data;
    logic        valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_error;
`endif

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ferr_cnt = 0;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .sclk           (sclk),
        .cs             (cs),
        .mosi           (mosi),
        .is_data_width_8(width8),
        .data           (data),
        .is_data_valid  (valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_error    (frame_error)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected unit, at the expected cycle.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got data 0x%08h at cycle %0d, none expected", data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_data", data, e.d);
                chk("pulse_cycle", 32'(cyc), 32'(e.c));
            end
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (rst_n && frame_error) ferr_cnt++;
`endif
    end

    task automatic spi_bit(input logic b, input bit last, input bit push, input logic [31:0] exp);
        exp_t e;
        mosi = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        if (last && push) begin
            e.d = exp;
            e.c = cyc + 4;
            q.push_back(e);
        end
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit push, input logic [31:0] exp);
        for (int i = 0; i < n; i++) spi_bit(b[7-i], i == 7, push, exp);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_byte(input logic [7:0] b, input bit push, input logic [31:0] exp);
        cs_low();
        send_bits(b, 8, push, exp);
        cs_high();
    endtask

    initial begin
        rst_n  = 1'b0;
        sclk   = 1'b0;
        cs     = 1'b1;
        mosi   = 1'b0;
        width8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", data, 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_data", data, 32'h0);

        // Byte mode
        frame_byte(8'h03, 1'b1, 32'h0000_0003);
        frame_byte(8'h10, 1'b1, 32'h0000_0010);
        frame_byte(8'h1D, 1'b1, 32'h0000_001D);

        // Word mode: four cs frames, single pulse on the last
        width8 = 1'b0;
        repeat (2) @(negedge clk);
        frame_byte(8'h00, 1'b0, 32'h0);
        frame_byte(8'h02, 1'b0, 32'h0);
        frame_byte(8'h00, 1'b0, 32'h0);
        chk("word_partial_hold", data, 32'h0000_001D);
        frame_byte(8'h03, 1'b1, 32'h0002_0003);
        repeat (4) @(negedge clk);
        chk("word_hold", data, 32'h0002_0003);

        // Streaming two bytes in one frame
        width8 = 1'b1;
        repeat (2) @(negedge clk);
        cs_low();
        send_bits(8'hA5, 8, 1'b1, 32'h0000_00A5);
        send_bits(8'h5A, 8, 1'b1, 32'h0000_005A);
        cs_high();

        // Abort after 5 bits, then a good byte
        ferr_cnt = 0;
        cs_low();
        send_bits(8'hFF, 5, 1'b0, 32'h0);
        cs_high();
        chk("abort_data_hold", data, 32'h0000_005A);
        frame_byte(8'h3C, 1'b1, 32'h0000_003C);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        chk("frame_error_count", 32'(ferr_cnt), 32'd1);
`endif

        // Reset mid-word, then full word
        width8 = 1'b0;
        repeat (2) @(negedge clk);
        frame_byte(8'h11, 1'b0, 32'h0);
        frame_byte(8'h22, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_data", data, 32'h0);
        chk("midreset_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame_byte(8'h11, 1'b0, 32'h0);
        frame_byte(8'h22, 1'b0, 32'h0);
        frame_byte(8'h33, 1'b0, 32'h0);
        frame_byte(8'h44, 1'b1, 32'h1122_3344);

        // sclk toggling with cs high is ignored
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            sclk = ~sclk;
            repeat (4) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("cs_high_ignored", data, 32'h1122_3344);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Receive-side SPI endpoint for the OLED driver's serial link. It oversamples `sclk`, `cs` and `mosi` with the system clock and shifts in MSB-first bits on rising `sclk` edges while `cs` is low. It reassembles either single bytes or 32-bit words sent as four consecutive `cs`-framed bytes, and presents each completed unit with a one-cycle valid strobe. It is the loop-back/capture counterpart of `spi_master`, used in the PL for self-test and for capturing traffic.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each of `sclk`, `cs`, `mosi`; legal 2..4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the master; idle level is don't-care.
- `cs`  in  1  chip select, active-low.
- `mosi`  in  1  serial data, MSB first.
- `is_data_width_8`  in  1  1 = each byte is a unit; 0 = four bytes form a 32-bit word.
- `data`  out  32  last completed unit; byte mode zero-extends into `data[7:0]`.
- `is_data_valid`  out  1  one-`clk` pulse when `data` updates.
- `frame_error`  out  1  present only with `SPI_SLAVE_FRAME_ERR_EN`; see Configuration.

## Operation
- All three inputs pass through `SYNC_STAGES` flops. One further flop provides edge detection: `sclk` rise, `cs` fall, `cs` rise.
- State `IDLE` (synced `cs`=1): no shifting. A `cs` fall moves the block to `SHIFT`.
  - If `byte_cnt`=0 at that fall, `is_data_width_8` is latched into `width8_q` for the whole unit.
- State `SHIFT` (synced `cs`=0):
  - On each synced `sclk` rise: `shreg <= {shreg[6:0], mosi_s}` and the 3-bit `bit_cnt` increments.
  - When the 8th bit lands (`bit_cnt`=7 → 0, wrapping), the byte is complete. `bit_cnt` wrap lets bytes stream back-to-back within one `cs` frame.
- Byte complete:
  - `width8_q`=1: `data <= {24'h0, byte}`, pulse `is_data_valid`.
  - `width8_q`=0: `word <= {word[23:0], byte}` and the 2-bit `byte_cnt` increments. On the 4th byte (`byte_cnt`=3 → 0), `data <= {word[23:0], byte}` and pulse `is_data_valid`.
- Synced `cs` rise returns the block to `IDLE`.
  - If `bit_cnt`≠0, the frame is aborted: the partial byte is discarded and `bit_cnt`, `byte_cnt` and `word` are cleared. `data` is untouched.
  - If `bit_cnt`=0, `byte_cnt` is preserved so the next `cs` frame continues the word.
- `sclk` edges while `cs` is high are ignored.
- A `cs` rise and an 8th-bit `sclk` rise in the same synced cycle: the byte completes first, then `cs` is processed with `bit_cnt`=0, so there is no abort.
- `data` holds its value until the next completion. There is no back-pressure; a consumer that misses a pulse loses that unit.

## Timing
- Reset values:
  - `data`=0, `is_data_valid`=0, `frame_error`=0.
  - State `IDLE`; `bit_cnt`=0, `byte_cnt`=0, `width8_q`=1.
- Latency: `is_data_valid` rises `SYNC_STAGES`+2 `clk` cycles after the pin-level `sclk` rise of the completing bit. That is 4 cycles at default, and it is exact.
- `is_data_valid` is high for exactly one cycle, aligned with the new `data`.
- Input constraints:
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+1 `clk` cycles.
  - `mosi` stable from ≥ `SYNC_STAGES`+1 cycles before the `sclk` rise until 1 cycle after it.
  - `cs` high pulse ≥ 2 cycles.
- Reset asserted mid-frame returns everything to reset values immediately. After release, the block waits for `cs` high before accepting a new `cs` fall.

## Configuration
- Macro `SPI_SLAVE_FRAME_ERR_EN`.
- Defined:
  - Port `frame_error` exists. It pulses for one cycle, coincident with the abort, on a `cs` rise with `bit_cnt`≠0.
  - It also pulses on a `cs` fall with `byte_cnt`≠0 when `is_data_width_8`=1 at that fall (width changed mid-word). In that case `byte_cnt` and `word` clear and the new unit starts in byte mode.
- Undefined: no port; aborts are silent and the width change follows the same clearing rule.

## Test plan
- Byte mode, `SCLK_DIVIDER`=20 master: send 0x03, 0x10, 0x1D → three pulses; `data`=0x00000003, 0x00000010, 0x0000001D; each pulse exactly 4 cycles after the 8th `sclk` rise.
- Word mode: master sends 0x00020003 as four `cs` frames → one pulse after the 4th frame; `data`=0x00020003; no pulse after frames 1-3.
- Streaming: two bytes 0xA5, 0x5A in one `cs` frame (16 `sclk` rises), byte mode → two pulses; `data`=0xA5 then 0x5A.
- Abort: `cs` rises after 5 bits of 0xFF, then a full byte 0x3C → single pulse with `data`=0x0000003C; `frame_error` pulses once (macro defined).
- Reset mid-word: `reset` low after byte 2 of 0x11223344, release, resend the full word → `data`=0x11223344; `data`=0 and `is_data_valid`=0 observed during reset.
- `sclk` toggling with `cs` high for 16 edges → no pulse, `data` unchanged.
